ieee_demo_counter: RTL and testbench

//   8-bit free-running up-counter with a count-enable input, for the workshop demo tile.

---
 rtl/ieee_demo_counter.sv | 57 +++++
 tb/tb_ieee_demo_counter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ieee_demo_counter.sv
// 8-bit up-counter with count enable for the workshop demo tile.
// Drives the count on uo_out, plus a one-cycle wrap pulse and an enable echo on uio.
module ieee_demo_counter #(
  parameter int unsigned     WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [WIDTH-1:0] CountMax = '1;

  logic [WIDTH-1:0] count_d, count_q;
  logic             wrap_d, wrap_q;
  logic             en_d, en_q;
  logic             count_en;

  // Only an explicit 1 counts; X/Z on the pin falls through to hold.
  assign count_en = (ui_in[0] == 1'b1);

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    en_d    = count_en;
    if (count_en) begin
      count_d = count_q + 1'b1;
      wrap_d  = (count_q == CountMax);
    end
  end

  // Note: rst_n is active-high here despite its name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      count_q <= RESET_VAL;
      wrap_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      en_q    <= en_d;
    end
  end

  assign uo_out  = count_q[7:0];
  assign uio_out = {6'b00_0000, en_q, wrap_q};
  assign uio_oe  = 8'b0000_0011;

  logic unused_inputs;
  assign unused_inputs = ^{ena, uio_in, ui_in[7:1]};

endmodule

// File: tb/tb_ieee_demo_counter.sv
// Directed self-checking bench for ieee_demo_counter.
module tb_ieee_demo_counter;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks;
  int n_fail;
  logic [7:0] exp_cnt;

  ieee_demo_counter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b1;
    ui_in  = 8'h01;
    ena    = 1'b1;
    uio_in = 8'hA5;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (uo_out !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_uo_out: got %h expected %h", uo_out, 8'h00);
      end
      n_checks++;
      if (uio_out !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_uio_out: got %h expected %h", uio_out, 8'h00);
      end
      n_checks++;
      if (uio_oe !== 8'h03) begin
        n_fail++;
        $display("FAIL reset_uio_oe: got %h expected %h", uio_oe, 8'h03);
      end
    end
    exp_cnt = 8'h00;
  endtask

  task automatic test_hold_after_reset();
    rst_n  = 1'b0;
    ui_in  = 8'hFE;
    uio_in = 8'hFF;
    ena    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (uo_out !== 8'h00) begin
        n_fail++;
        $display("FAIL hold_idle_uo_out: got %h expected %h", uo_out, 8'h00);
      end
      n_checks++;
      if (uio_out !== 8'h00) begin
        n_fail++;
        $display("FAIL hold_idle_uio_out: got %h expected %h", uio_out, 8'h00);
      end
    end
  endtask

  task automatic test_count();
    ui_in = 8'h01;
    for (int i = 1; i <= 10; i++) begin
      step();
      exp_cnt = 8'(i);
      n_checks++;
      if (uo_out !== exp_cnt) begin
        n_fail++;
        $display("FAIL count_uo_out: got %h expected %h", uo_out, exp_cnt);
      end
      n_checks++;
      if (uio_out !== 8'h02) begin
        n_fail++;
        $display("FAIL count_uio_out: got %h expected %h", uio_out, 8'h02);
      end
    end
  endtask

  task automatic test_hold();
    ui_in = 8'h80;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (uo_out !== 8'h0A) begin
        n_fail++;
        $display("FAIL hold_uo_out: got %h expected %h", uo_out, 8'h0A);
      end
      n_checks++;
      if (uio_out !== 8'h00) begin
        n_fail++;
        $display("FAIL hold_uio_out: got %h expected %h", uio_out, 8'h00);
      end
    end
    exp_cnt = 8'h0A;
  endtask

  task automatic test_wrap();
    int         pulses;
    logic [7:0] start;
    logic [7:0] exp_uio;
    pulses = 0;
    start  = exp_cnt;
    ui_in  = 8'h01;
    for (int i = 0; i < 256; i++) begin
      step();
      exp_cnt = exp_cnt + 8'd1;
      exp_uio = {6'b0, 1'b1, (exp_cnt == 8'h00)};
      if (uio_out[0] === 1'b1) pulses++;
      n_checks++;
      if (uo_out !== exp_cnt) begin
        n_fail++;
        $display("FAIL wrap_uo_out: got %h expected %h", uo_out, exp_cnt);
      end
      n_checks++;
      if (uio_out !== exp_uio) begin
        n_fail++;
        $display("FAIL wrap_uio_out: got %h expected %h at count %h", uio_out, exp_uio, exp_cnt);
      end
    end
    n_checks++;
    if (uo_out !== start) begin
      n_fail++;
      $display("FAIL wrap_return: got %h expected %h", uo_out, start);
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL wrap_pulse_count: got %0d expected %0d", pulses, 1);
    end
  endtask

  // Park at 0xFF with enable low: no wrap, then one enabled edge wraps.
  task automatic test_wrap_hold_at_max();
    ui_in = 8'h01;
    while (exp_cnt != 8'hFF) begin
      step();
      exp_cnt = exp_cnt + 8'd1;
    end
    ui_in = 8'h00;
    step();
    n_checks++;
    if ({uo_out, uio_out} !== {8'hFF, 8'h00}) begin
      n_fail++;
      $display("FAIL max_hold: got %h/%h expected ff/00", uo_out, uio_out);
    end
    ui_in = 8'h01;
    step();
    exp_cnt = 8'h00;
    n_checks++;
    if ({uo_out, uio_out} !== {8'h00, 8'h03}) begin
      n_fail++;
      $display("FAIL max_wrap: got %h/%h expected 00/03", uo_out, uio_out);
    end
    step();
    exp_cnt = 8'h01;
    n_checks++;
    if ({uo_out, uio_out} !== {8'h01, 8'h02}) begin
      n_fail++;
      $display("FAIL post_wrap: got %h/%h expected 01/02", uo_out, uio_out);
    end
  endtask

  task automatic test_mid_reset();
    ui_in = 8'h01;
    while (exp_cnt != 8'h37) begin
      step();
      exp_cnt = exp_cnt + 8'd1;
    end
    n_checks++;
    if (uo_out !== 8'h37) begin
      n_fail++;
      $display("FAIL pre_reset: got %h expected %h", uo_out, 8'h37);
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({uo_out, uio_out} !== {8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL mid_reset: got %h/%h expected 00/00", uo_out, uio_out);
    end
    rst_n = 1'b0;
    step();
    n_checks++;
    if ({uo_out, uio_out} !== {8'h01, 8'h02}) begin
      n_fail++;
      $display("FAIL resume: got %h/%h expected 01/02", uo_out, uio_out);
    end
    step();
    exp_cnt = 8'h02;
    n_checks++;
    if (uo_out !== 8'h02) begin
      n_fail++;
      $display("FAIL resume2: got %h expected %h", uo_out, 8'h02);
    end
  endtask

  // Alternating enable; also confirms outputs do not move between edges.
  task automatic test_back_to_back();
    logic [7:0] en_pat;
    logic [7:0] snap_uo;
    logic [7:0] snap_uio;
    en_pat = 8'b1011_0110;
    for (int i = 0; i < 8; i++) begin
      snap_uo  = uo_out;
      snap_uio = uio_out;
      ui_in    = {7'h55, en_pat[i]};
      ena      = ~ena;
      uio_in   = ~uio_in;
      #1;
      n_checks++;
      if ({uo_out, uio_out} !== {snap_uo, snap_uio}) begin
        n_fail++;
        $display("FAIL comb_path: got %h/%h expected %h/%h", uo_out, uio_out, snap_uo, snap_uio);
      end
      step();
      if (en_pat[i]) exp_cnt = exp_cnt + 8'd1;
      n_checks++;
      if ({uo_out, uio_out} !== {exp_cnt, 6'b0, en_pat[i], 1'b0}) begin
        n_fail++;
        $display("FAIL b2b: got %h/%h expected %h/%h", uo_out, uio_out, exp_cnt,
                 {6'b0, en_pat[i], 1'b0});
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_cnt  = 8'h00;
    rst_n    = 1'b1;
    ena      = 1'b0;
    ui_in    = 8'h00;
    uio_in   = 8'h00;
    test_reset();
    test_hold_after_reset();
    test_count();
    test_hold();
    test_wrap();
    test_wrap_hold_at_max();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
